// File: rtl/alu_uart_sequencer_if.sv
// Bundle of the UART receive/transmit handshakes, ALU operand/result buses and status
// flags between the sequencer (slave) and its environment (master).
interface alu_uart_sequencer_if #(
  parameter int DBIT        = 8,
  parameter int NB_OP       = 6,
  parameter int N_RES_BYTES = 1
);
  localparam int NB_RES = N_RES_BYTES * DBIT;

  logic              i_rx_done_tick;
  logic [DBIT-1:0]   i_rx_data;
  logic [NB_RES-1:0] i_alu_result;
  logic              i_tx_done_tick;
  logic [DBIT-1:0]   o_data_a;
  logic [DBIT-1:0]   o_data_b;
  logic [NB_OP-1:0]  o_operation;
  logic              o_tx_start;
  logic [DBIT-1:0]   o_tx_data;
  logic              o_busy;
  logic              o_timeout_err;

  modport slave (
    input  i_rx_done_tick, i_rx_data, i_alu_result, i_tx_done_tick,
    output o_data_a, o_data_b, o_operation, o_tx_start, o_tx_data, o_busy, o_timeout_err
  );

  modport master (
    output i_rx_done_tick, i_rx_data, i_alu_result, i_tx_done_tick,
    input  o_data_a, o_data_b, o_operation, o_tx_start, o_tx_data, o_busy, o_timeout_err
  );
endinterface

// File: rtl/alu_uart_sequencer.sv
// Collects A, B and opcode bytes from a UART receiver, latches the ALU result and
// streams it LSB byte first to a UART transmitter; stalled frames are aborted by timeout.
module alu_uart_sequencer #(
  parameter int DBIT           = 8,
  parameter int NB_OP          = 6,
  parameter int N_RES_BYTES    = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  alu_uart_sequencer_if.slave       sif
);
  localparam int NB_RES = N_RES_BYTES * DBIT;
  localparam int CW     = (N_RES_BYTES > 1) ? $clog2(N_RES_BYTES) : 1;
  localparam int TW     = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_B     = 3'd1,
    GET_OP    = 3'd2,
    EXEC      = 3'd3,
    SEND      = 3'd4,
    WAIT_DONE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [DBIT-1:0]   data_a_q, data_a_d;
  logic [DBIT-1:0]   data_b_q, data_b_d;
  logic [NB_OP-1:0]  operation_q, operation_d;
  logic [NB_RES-1:0] shreg_q, shreg_d, shreg_nx;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              tx_start_q, tx_start_d;
  logic [DBIT-1:0]   tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              timeout_err_q, timeout_err_d;
  logic              tmo_expire_s;

  // The timeout counter is zero outside GET_B/GET_OP, so entering either state starts it
  // from zero; expiry is judged on the pre-increment value to fire on the 15th idle edge.
  assign tmo_expire_s = (tmo_q == TW'(TIMEOUT_CYCLES - 2));
  assign shreg_nx     = shreg_q >> DBIT;

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    data_a_d      = data_a_q;
    data_b_d      = data_b_q;
    operation_d   = operation_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    tmo_d         = {TW{1'b0}};
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (sif.i_rx_done_tick) begin
          data_a_d = sif.i_rx_data;
          state_d  = GET_B;
        end else begin
          state_d = IDLE;
        end
      end
      GET_B: begin
        if (sif.i_rx_done_tick) begin
          data_b_d = sif.i_rx_data;
          state_d  = GET_OP;
        end else if (tmo_expire_s) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GET_OP: begin
        if (sif.i_rx_done_tick) begin
          operation_d = sif.i_rx_data[NB_OP-1:0];
          state_d     = EXEC;
        end else if (tmo_expire_s) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      EXEC: begin
        shreg_d    = sif.i_alu_result;
        cnt_d      = {CW{1'b0}};
        tx_start_d = 1'b1;
        tx_data_d  = sif.i_alu_result[DBIT-1:0];
        state_d    = SEND;
      end
      SEND: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (sif.i_tx_done_tick) begin
          shreg_d = shreg_nx;
          if (cnt_q == CW'(N_RES_BYTES - 1)) begin
            state_d = IDLE;
          end else begin
            cnt_d      = cnt_q + CW'(1);
            tx_start_d = 1'b1;
            tx_data_d  = shreg_nx[DBIT-1:0];
            state_d    = SEND;
          end
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q       <= IDLE;
      data_a_q      <= {DBIT{1'b0}};
      data_b_q      <= {DBIT{1'b0}};
      operation_q   <= {NB_OP{1'b0}};
      shreg_q       <= {NB_RES{1'b0}};
      cnt_q         <= {CW{1'b0}};
      tmo_q         <= {TW{1'b0}};
      tx_start_q    <= 1'b0;
      tx_data_q     <= {DBIT{1'b0}};
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_a_q      <= data_a_d;
      data_b_q      <= data_b_d;
      operation_q   <= operation_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign sif.o_data_a      = data_a_q;
  assign sif.o_data_b      = data_b_q;
  assign sif.o_operation   = operation_q;
  assign sif.o_tx_start    = tx_start_q;
  assign sif.o_tx_data     = tx_data_q;
  assign sif.o_busy        = busy_q;
  assign sif.o_timeout_err = timeout_err_q;
endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench: u1 is a single-byte-result sequencer (ALU = A+B), u2 a two-byte one
// (ALU = {A,B}); both use a 16-cycle timeout.
module tb_alu_uart_sequencer;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   starts1 = 0;
  int   starts2 = 0;
  int   base;

  alu_uart_sequencer_if #(.DBIT(8), .NB_OP(6), .N_RES_BYTES(1)) bus1 ();
  alu_uart_sequencer_if #(.DBIT(8), .NB_OP(6), .N_RES_BYTES(2)) bus2 ();

  alu_uart_sequencer #(.DBIT(8), .NB_OP(6), .N_RES_BYTES(1), .TIMEOUT_CYCLES(16)) u1 (
    .i_clk(clk), .i_reset(rst_n), .sif(bus1)
  );
  alu_uart_sequencer #(.DBIT(8), .NB_OP(6), .N_RES_BYTES(2), .TIMEOUT_CYCLES(16)) u2 (
    .i_clk(clk), .i_reset(rst_n), .sif(bus2)
  );

  assign bus1.i_alu_result = bus1.o_data_a + bus1.o_data_b;
  assign bus2.i_alu_result = {bus2.o_data_a, bus2.o_data_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus1.o_tx_start) starts1 <= starts1 + 1;
    if (bus2.o_tx_start) starts2 <= starts2 + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rx(input int which, input logic [7:0] b);
    if (which == 1) begin
      bus1.i_rx_done_tick = 1'b1;
      bus1.i_rx_data      = b;
    end else begin
      bus2.i_rx_done_tick = 1'b1;
      bus2.i_rx_data      = b;
    end
    tick(1);
    bus1.i_rx_done_tick = 1'b0;
    bus2.i_rx_done_tick = 1'b0;
  endtask

  task automatic txdone(input int which);
    if (which == 1) bus1.i_tx_done_tick = 1'b1;
    else            bus2.i_tx_done_tick = 1'b1;
    tick(1);
    bus1.i_tx_done_tick = 1'b0;
    bus2.i_tx_done_tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus1.i_rx_done_tick = 1'b0; bus1.i_rx_data = 8'h00; bus1.i_tx_done_tick = 1'b0;
    bus2.i_rx_done_tick = 1'b0; bus2.i_rx_data = 8'h00; bus2.i_tx_done_tick = 1'b0;
    tick(2);
    chk("rst_a",    32'(bus1.o_data_a),      32'h0);
    chk("rst_b",    32'(bus1.o_data_b),      32'h0);
    chk("rst_op",   32'(bus1.o_operation),   32'h0);
    chk("rst_start",32'(bus1.o_tx_start),    32'h0);
    chk("rst_txd",  32'(bus1.o_tx_data),     32'h0);
    chk("rst_busy", 32'(bus1.o_busy),        32'h0);
    chk("rst_err",  32'(bus1.o_timeout_err), 32'h0);
    rst_n = 1'b1;
    tick(1);

    // Basic frame on u1: 5 + 3 = 8.
    base = starts1;
    rx(1, 8'h05);
    chk("busy_after_a", 32'(bus1.o_busy), 32'h1);
    rx(1, 8'h03);
    rx(1, 8'h20);
    chk("basic_a",  32'(bus1.o_data_a),    32'h05);
    chk("basic_b",  32'(bus1.o_data_b),    32'h03);
    chk("basic_op", 32'(bus1.o_operation), 32'h20);
    chk("exec_no_start", 32'(bus1.o_tx_start), 32'h0);
    tick(1);
    chk("basic_start", 32'(bus1.o_tx_start), 32'h1);
    chk("basic_txd",   32'(bus1.o_tx_data),  32'h08);
    tick(1);
    chk("start_pulse_end", 32'(bus1.o_tx_start), 32'h0);
    // Ignored rx bytes while waiting for the transmitter.
    rx(1, 8'hFF);
    rx(1, 8'hFF);
    chk("ign_a",    32'(bus1.o_data_a),    32'h05);
    chk("ign_b",    32'(bus1.o_data_b),    32'h03);
    chk("ign_op",   32'(bus1.o_operation), 32'h20);
    chk("ign_txd",  32'(bus1.o_tx_data),   32'h08);
    chk("ign_busy", 32'(bus1.o_busy),      32'h1);
    tick(6);
    txdone(1);
    chk("basic_idle",   32'(bus1.o_busy), 32'h0);
    chk("basic_starts", 32'(starts1 - base), 32'd1);

    // Two-byte result on u2: {0x12,0x34}, LSB first.
    base = starts2;
    rx(2, 8'h12);
    rx(2, 8'h34);
    rx(2, 8'h07);
    tick(1);
    chk("mb_start0", 32'(bus2.o_tx_start), 32'h1);
    chk("mb_txd0",   32'(bus2.o_tx_data),  32'h34);
    tick(3);
    chk("mb_hold_txd", 32'(bus2.o_tx_data), 32'h34);
    chk("mb_one_start", 32'(starts2 - base), 32'd1);
    txdone(2);
    chk("mb_start1", 32'(bus2.o_tx_start), 32'h1);
    chk("mb_txd1",   32'(bus2.o_tx_data),  32'h12);
    tick(2);
    chk("mb_busy_mid", 32'(bus2.o_busy), 32'h1);
    txdone(2);
    chk("mb_idle",   32'(bus2.o_busy), 32'h0);
    chk("mb_starts", 32'(starts2 - base), 32'd2);

    // Timeout on u1 after a lone A byte.
    rx(1, 8'hAA);
    tick(14);
    chk("to_not_yet",  32'(bus1.o_timeout_err), 32'h0);
    chk("to_busy_pre", 32'(bus1.o_busy),        32'h1);
    tick(1);
    chk("to_pulse",  32'(bus1.o_timeout_err), 32'h1);
    chk("to_idle",   32'(bus1.o_busy),        32'h0);
    chk("to_keep_a", 32'(bus1.o_data_a),      32'hAA);
    chk("to_keep_b", 32'(bus1.o_data_b),      32'h03);
    tick(1);
    chk("to_pulse_end", 32'(bus1.o_timeout_err), 32'h0);
    rx(1, 8'h11);
    chk("to_next_a", 32'(bus1.o_data_a), 32'h11);

    // Opcode truncation: 0xE6 -> 0x26; result 0x11 + 0x22.
    rx(1, 8'h22);
    rx(1, 8'hE6);
    chk("trunc_op", 32'(bus1.o_operation), 32'h26);
    tick(1);
    chk("trunc_txd", 32'(bus1.o_tx_data), 32'h33);
    tick(2);
    txdone(1);
    chk("trunc_idle", 32'(bus1.o_busy), 32'h0);

    // Back-to-back frame; B arrives on the very edge the timeout would expire.
    rx(1, 8'h40);
    tick(14);
    rx(1, 8'h01);
    chk("race_no_err", 32'(bus1.o_timeout_err), 32'h0);
    chk("race_b",      32'(bus1.o_data_b),      32'h01);
    chk("race_busy",   32'(bus1.o_busy),        32'h1);
    rx(1, 8'h3F);
    chk("b2b_op", 32'(bus1.o_operation), 32'h3F);
    tick(1);
    chk("b2b_start", 32'(bus1.o_tx_start), 32'h1);
    chk("b2b_txd",   32'(bus1.o_tx_data),  32'h41);
    tick(2);
    txdone(1);
    chk("b2b_idle", 32'(bus1.o_busy), 32'h0);

    // Reset during WAIT_DONE on u2.
    rx(2, 8'hAB);
    rx(2, 8'hCD);
    rx(2, 8'h01);
    tick(4);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("mr_a",     32'(bus2.o_data_a),      32'h0);
    chk("mr_b",     32'(bus2.o_data_b),      32'h0);
    chk("mr_op",    32'(bus2.o_operation),   32'h0);
    chk("mr_start", 32'(bus2.o_tx_start),    32'h0);
    chk("mr_txd",   32'(bus2.o_tx_data),     32'h0);
    chk("mr_busy",  32'(bus2.o_busy),        32'h0);
    chk("mr_err",   32'(bus2.o_timeout_err), 32'h0);
    base = starts2;
    tick(5);
    txdone(2);
    tick(2);
    chk("mr_no_start", 32'(starts2 - base), 32'd0);
    chk("mr_stay_idle", 32'(bus2.o_busy),   32'h0);
    rx(2, 8'h56);
    rx(2, 8'h78);
    rx(2, 8'h00);
    tick(1);
    chk("post_txd0", 32'(bus2.o_tx_data), 32'h78);
    tick(2);
    txdone(2);
    chk("post_txd1", 32'(bus2.o_tx_data), 32'h56);
    tick(2);
    txdone(2);
    chk("post_idle",   32'(bus2.o_busy), 32'h0);
    chk("post_starts", 32'(starts2 - base), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
